// File: rtl/ram_write_serializer_if.sv
// Client write/read ports and RAM-side bus of the write serializer.
// The serializer takes the slave view; the client/RAM side takes the master view.
interface ram_write_serializer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  WrValid_SI_0;
    logic                  WrReady_SO_0;
    logic [ADDR_WIDTH-1:0] WrAddr_DI_0;
    logic [DATA_WIDTH-1:0] WrData_DI_0;
    logic                  WrValid_SI_1;
    logic                  WrReady_SO_1;
    logic [ADDR_WIDTH-1:0] WrAddr_DI_1;
    logic [DATA_WIDTH-1:0] WrData_DI_1;
    logic [ADDR_WIDTH-1:0] RdAddr_DI_0;
    logic [ADDR_WIDTH-1:0] RdAddr_DI_1;
    logic [DATA_WIDTH-1:0] RdData_DO_0;
    logic [DATA_WIDTH-1:0] RdData_DO_1;
    logic                  RamWrEn_SO;
    logic [ADDR_WIDTH-1:0] RamWrAddr_DO;
    logic [DATA_WIDTH-1:0] RamWrData_DO;
    logic [ADDR_WIDTH-1:0] RamRdAddr_DO_0;
    logic [ADDR_WIDTH-1:0] RamRdAddr_DO_1;
    logic [DATA_WIDTH-1:0] RamRdData_DI_0;
    logic [DATA_WIDTH-1:0] RamRdData_DI_1;
    logic                  InitDone_SO;

    modport slave (
        input  WrValid_SI_0, WrAddr_DI_0, WrData_DI_0,
               WrValid_SI_1, WrAddr_DI_1, WrData_DI_1,
               RdAddr_DI_0, RdAddr_DI_1, RamRdData_DI_0, RamRdData_DI_1,
        output WrReady_SO_0, WrReady_SO_1, RdData_DO_0, RdData_DO_1,
               RamWrEn_SO, RamWrAddr_DO, RamWrData_DO,
               RamRdAddr_DO_0, RamRdAddr_DO_1, InitDone_SO
    );

    modport master (
        output WrValid_SI_0, WrAddr_DI_0, WrData_DI_0,
               WrValid_SI_1, WrAddr_DI_1, WrData_DI_1,
               RdAddr_DI_0, RdAddr_DI_1, RamRdData_DI_0, RamRdData_DI_1,
        input  WrReady_SO_0, WrReady_SO_1, RdData_DO_0, RdData_DO_1,
               RamWrEn_SO, RamWrAddr_DO, RamWrData_DO,
               RamRdAddr_DO_0, RamRdAddr_DO_1, InitDone_SO
    );
endinterface

// File: rtl/ram_write_serializer.sv
// Front end for a 1W2R asynchronous RAM: clears the RAM after reset, then
// queues up to two writes per cycle, drains one per cycle, and forwards
// pending data to the two read ports.
module ram_write_serializer #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_DEPTH = 1024,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    ram_write_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0]      LAST_SLOT    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE_FREE = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_TWO_FREE = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(DATA_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_done;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, wr_ptr_p1, wr_ptr_nxt, slot1;
    logic [CNT_W-1:0]      count, count_nxt;

    // last values driven on the write port, held while the queue is empty
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;

    logic                  run, ready0, ready1, push0, push1, pop;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data0, rd_data1;
    logic [PTR_W-1:0]      fwd_slot;

    function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    // Readies look at the registered count only. They are also held low
    // during a reset cycle so nothing is accepted that is about to be dropped.
    assign run    = (state == ST_RUN);
    assign ready0 = run && Rst_RBI && (count <= CNT_ONE_FREE);
    assign ready1 = run && Rst_RBI && (count <= CNT_TWO_FREE);
    assign push0  = bus.WrValid_SI_0 && ready0;
    assign push1  = bus.WrValid_SI_1 && ready1;
    // A reset cycle must not commit the head entry to the RAM.
    assign pop    = run && Rst_RBI && (count != '0);

    assign wr_ptr_p1 = next_slot(wr_ptr);
    assign slot1     = push0 ? wr_ptr_p1 : wr_ptr;
    assign count_nxt = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);

    // Pointer advance for zero, one or two pushes.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        if (push0 && push1)     wr_ptr_nxt = next_slot(wr_ptr_p1);
        else if (push0 || push1) wr_ptr_nxt = wr_ptr_p1;
    end

    // Write-port mux: clear sequence in INIT, FIFO head in RUN, else hold.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = hold_addr;
        wr_data = hold_data;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt;
            wr_data = INIT_VALUE;
        end else if (pop) begin
            wr_en   = 1'b1;
            wr_addr = fifo_addr[rd_ptr];
            wr_data = fifo_data[rd_ptr];
        end
    end

    // Read forwarding: walk the queue oldest to youngest so the last match
    // (the youngest write to that address) wins. The head is included.
    always_comb begin
        rd_data0 = bus.RamRdData_DI_0;
        rd_data1 = bus.RamRdData_DI_1;
        fwd_slot = rd_ptr;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (run && (CNT_W'(k) < count)) begin
                if (fifo_addr[fwd_slot] == bus.RdAddr_DI_0) rd_data0 = fifo_data[fwd_slot];
                if (fifo_addr[fwd_slot] == bus.RdAddr_DI_1) rd_data1 = fifo_data[fwd_slot];
            end
            fwd_slot = next_slot(fwd_slot);
        end
    end

    // FIFO storage; port 0 lands first so port 1 is the younger entry.
    always_ff @(posedge Clk_CI) begin
        if (push0) begin
            fifo_addr[wr_ptr] <= bus.WrAddr_DI_0;
            fifo_data[wr_ptr] <= bus.WrData_DI_0;
        end
        if (push1) begin
            fifo_addr[slot1] <= bus.WrAddr_DI_1;
            fifo_data[slot1] <= bus.WrData_DI_1;
        end
    end

    // INIT -> RUN sequencer plus queue pointers and write-port hold registers.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            if (wr_en) begin
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pop) rd_ptr <= next_slot(rd_ptr);
                    wr_ptr <= wr_ptr_nxt;
                    count  <= count_nxt;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.WrReady_SO_0   = ready0;
    assign bus.WrReady_SO_1   = ready1;
    assign bus.RdData_DO_0    = rd_data0;
    assign bus.RdData_DO_1    = rd_data1;
    assign bus.RamWrEn_SO     = wr_en;
    assign bus.RamWrAddr_DO   = wr_addr;
    assign bus.RamWrData_DO   = wr_data;
    assign bus.RamRdAddr_DO_0 = bus.RdAddr_DI_0;
    assign bus.RamRdAddr_DO_1 = bus.RdAddr_DI_1;
    assign bus.InitDone_SO    = init_done;

    // Accepted addresses must fall inside the RAM.
    a_addr0_range: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        push0 |-> (int'(bus.WrAddr_DI_0) < DATA_DEPTH));
    a_addr1_range: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        push1 |-> (int'(bus.WrAddr_DI_1) < DATA_DEPTH));
endmodule

// File: tb/tb_ram_write_serializer.sv
// Directed bench for ram_write_serializer with a small behavioural RAM.
module tb_ram_write_serializer;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seed = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];

    ram_write_serializer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    ram_write_serializer #(
        .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW),
        .FIFO_DEPTH(4), .INIT_VALUE(16'h0000)
    ) dut (
        .Clk_CI(clk),
        .Rst_RBI(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read, plus a write log.
    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 16'hDEAD;
        end else if (bus.RamWrEn_SO) begin
            mem[bus.RamWrAddr_DO] <= bus.RamWrData_DO;
            log_addr.push_back(bus.RamWrAddr_DO);
            log_data.push_back(bus.RamWrData_DO);
        end
    end
    assign bus.RamRdData_DI_0 = mem[bus.RamRdAddr_DO_0];
    assign bus.RamRdData_DI_1 = mem[bus.RamRdAddr_DO_1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.WrValid_SI_0 = v0; bus.WrAddr_DI_0 = a0; bus.WrData_DI_0 = d0;
        bus.WrValid_SI_1 = v1; bus.WrAddr_DI_1 = a1; bus.WrData_DI_1 = d1;
    endtask

    // Called at the negedge where reset has just been released.
    task automatic init_seq(input string tag);
        int base;
        base = log_addr.size();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk({tag, "_we"},    32'(bus.RamWrEn_SO),   32'd1);
            chk({tag, "_addr"},  32'(bus.RamWrAddr_DO), i);
            chk({tag, "_data"},  32'(bus.RamWrData_DO), 32'd0);
            chk({tag, "_rdy0"},  32'(bus.WrReady_SO_0), 32'd0);
            chk({tag, "_rdy1"},  32'(bus.WrReady_SO_1), 32'd0);
            chk({tag, "_done0"}, 32'(bus.InitDone_SO),  32'd0);
            tick();
        end
        #1;
        chk({tag, "_done1"},   32'(bus.InitDone_SO),  32'd1);
        chk({tag, "_rdy0run"}, 32'(bus.WrReady_SO_0), 32'd1);
        chk({tag, "_rdy1run"}, 32'(bus.WrReady_SO_1), 32'd1);
        chk({tag, "_we_idle"}, 32'(bus.RamWrEn_SO),   32'd0);
        chk({tag, "_nwrites"}, log_addr.size() - base, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < log_addr.size()) begin
                chk({tag, "_log_addr"}, 32'(log_addr[base + i]), i);
                chk({tag, "_log_data"}, 32'(log_data[base + i]), 32'd0);
            end
        end
    endtask

    initial begin
        int base;
        logic [AW-1:0] ea [$];
        logic [DW-1:0] ed [$];

        drive(0, 0, 0, 0, 0, 0);
        bus.RdAddr_DI_0 = '0;
        bus.RdAddr_DI_1 = '0;

        // reset state
        tick();
        seed = 1'b0;
        tick();
        #1;
        chk("rst_done",  32'(bus.InitDone_SO),  32'd0);
        chk("rst_rdy0",  32'(bus.WrReady_SO_0), 32'd0);
        chk("rst_rdy1",  32'(bus.WrReady_SO_1), 32'd0);
        chk("rst_waddr", 32'(bus.RamWrAddr_DO), 32'd0);

        // clear sequence
        rst_n = 1'b1;
        init_seq("init");
        chk("init_mem0", 32'(mem[0]), 32'd0);
        chk("init_mem7", 32'(mem[7]), 32'd0);

        // dual write, empty queue; incoming data is not forwarded same cycle
        drive(1, 3, 16'hAAAA, 1, 5, 16'hBBBB);
        bus.RdAddr_DI_0 = 3;
        #1;
        chk("dual_rdy0", 32'(bus.WrReady_SO_0), 32'd1);
        chk("dual_rdy1", 32'(bus.WrReady_SO_1), 32'd1);
        chk("dual_nofwd_same_cycle", 32'(bus.RdData_DO_0), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.RdAddr_DI_0 = 5;
        #1;
        chk("dual_we1",   32'(bus.RamWrEn_SO),   32'd1);
        chk("dual_addr1", 32'(bus.RamWrAddr_DO), 32'd3);
        chk("dual_data1", 32'(bus.RamWrData_DO), 32'hAAAA);
        chk("dual_fwd5",  32'(bus.RdData_DO_0),  32'hBBBB);
        chk("dual_ram5_old", 32'(mem[5]), 32'd0);
        tick();
        #1;
        chk("dual_we2",   32'(bus.RamWrEn_SO),   32'd1);
        chk("dual_addr2", 32'(bus.RamWrAddr_DO), 32'd5);
        chk("dual_data2", 32'(bus.RamWrData_DO), 32'hBBBB);
        chk("dual_ram3",  32'(mem[3]), 32'hAAAA);
        tick();
        #1;
        chk("dual_we_idle",   32'(bus.RamWrEn_SO),   32'd0);
        chk("dual_addr_hold", 32'(bus.RamWrAddr_DO), 32'd5);
        chk("dual_data_hold", 32'(bus.RamWrData_DO), 32'hBBBB);
        chk("dual_ram5",      32'(mem[5]), 32'hBBBB);
        chk("dual_rd_ram",    32'(bus.RdData_DO_0), 32'hBBBB);

        // same address in one cycle: port 1 is younger
        base = log_addr.size();
        drive(1, 7, 16'h1111, 1, 7, 16'h2222);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.RdAddr_DI_0 = 7;
        #1;
        chk("same_fwd_both",  32'(bus.RdData_DO_0),  32'h2222);
        chk("same_head_data", 32'(bus.RamWrData_DO), 32'h1111);
        tick();
        #1;
        chk("same_fwd_one",   32'(bus.RdData_DO_0),  32'h2222);
        chk("same_head2",     32'(bus.RamWrData_DO), 32'h2222);
        tick();
        #1;
        chk("same_ram7",    32'(mem[7]), 32'h2222);
        chk("same_nwrites", log_addr.size() - base, 32'd2);
        if (log_addr.size() >= base + 2) begin
            chk("same_order0", 32'({log_addr[base], log_data[base]}),         {12'd0, 4'd7, 16'h1111});
            chk("same_order1", 32'({log_addr[base + 1], log_data[base + 1]}), {12'd0, 4'd7, 16'h2222});
        end

        // backpressure: dual writes every cycle. One entry drains per cycle,
        // so the count settles at 3 and only port 1 is throttled.
        base = log_addr.size();
        for (int c = 0; c < 5; c++) begin
            drive(1, AW'(c), 16'h1000 + DW'(c), 1, AW'(7 - c), 16'h2000 + DW'(c));
            #1;
            chk("bp_rdy0", 32'(bus.WrReady_SO_0), 32'd1);
            chk("bp_rdy1", 32'(bus.WrReady_SO_1), (c < 2) ? 32'd1 : 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("bp_rdy0_cnt3", 32'(bus.WrReady_SO_0), 32'd1);
        chk("bp_rdy1_cnt3", 32'(bus.WrReady_SO_1), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        // accepted: A0 B0 A1 B1 A2 A3 A4
        ea = '{4'd0, 4'd7, 4'd1, 4'd6, 4'd2, 4'd3, 4'd4};
        ed = '{16'h1000, 16'h2000, 16'h1001, 16'h2001, 16'h1002, 16'h1003, 16'h1004};
        chk("bp_nwrites", log_addr.size() - base, 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (base + i < log_addr.size()) begin
                chk("bp_log_addr", 32'(log_addr[base + i]), 32'(ea[i]));
                chk("bp_log_data", 32'(log_data[base + i]), 32'(ed[i]));
            end
        end

        // reset with three entries pending
        drive(1, 1, 16'h3001, 1, 2, 16'h3002);
        tick();
        drive(1, 3, 16'h3003, 1, 4, 16'h3004);
        #1;
        chk("rst_mid_rdy1", 32'(bus.WrReady_SO_1), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        base = log_addr.size();
        #1;
        chk("rst_mid_we_gated", 32'(bus.RamWrEn_SO), 32'd0);
        tick();
        chk("rst_mid_nowrite", log_addr.size(), base);
        rst_n = 1'b1;
        init_seq("reinit");

        // no-match read passes RAM data through; match forwards
        drive(1, 4, 16'h5555, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 16'h4444, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.RdAddr_DI_0 = 2;
        bus.RdAddr_DI_1 = 4;
        #1;
        chk("nomatch_rd1", 32'(bus.RdData_DO_1),  32'h5555);
        chk("match_rd0",   32'(bus.RdData_DO_0),  32'h4444);
        chk("nm_head",     32'(bus.RamWrAddr_DO), 32'd2);
        tick();
        #1;
        chk("nm_rd0_ram",  32'(bus.RdData_DO_0),  32'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_write_serializer.md
Name: ram_write_serializer

Overview:
- Front-end stage that drives the write port and both read ports of the team's asynchronous three-port (1W2R) RAM.
- Accepts up to two write requests per cycle on valid/ready ports and queues them in a small pending FIFO. Drains one write per cycle onto the single RAM write port.
- Forwards still-pending data onto the two read ports, so reads always see the latest accepted write.
- After reset, sequences a clear of the whole RAM before accepting traffic.

Parameters:
ADDR_WIDTH, 10, RAM address width
DATA_DEPTH, 1024, number of RAM words; must be <= 2**ADDR_WIDTH
DATA_WIDTH, 32, word width
FIFO_DEPTH, 4, pending-write entries; must be >= 2
INIT_VALUE, 0, value written to every RAM word during the clear sequence

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, synchronous, active-low
WrValid_SI_0  in  1  write request, port 0 (older when both fire)
WrReady_SO_0  out  1  port 0 accept
WrAddr_DI_0  in  ADDR_WIDTH  port 0 address
WrData_DI_0  in  DATA_WIDTH  port 0 data
WrValid_SI_1  in  1  write request, port 1
WrReady_SO_1  out  1  port 1 accept
WrAddr_DI_1  in  ADDR_WIDTH  port 1 address
WrData_DI_1  in  DATA_WIDTH  port 1 data
RdAddr_DI_0  in  ADDR_WIDTH  client read address 0
RdAddr_DI_1  in  ADDR_WIDTH  client read address 1
RdData_DO_0  out  DATA_WIDTH  forwarded read data 0
RdData_DO_1  out  DATA_WIDTH  forwarded read data 1
RamWrEn_SO  out  1  to RAM WrEn_SI
RamWrAddr_DO  out  ADDR_WIDTH  to RAM WrAddr_DI
RamWrData_DO  out  DATA_WIDTH  to RAM WrData_DI
RamRdAddr_DO_0  out  ADDR_WIDTH  to RAM read addr 0 (= RdAddr_DI_0)
RamRdAddr_DO_1  out  ADDR_WIDTH  to RAM read addr 1 (= RdAddr_DI_1)
RamRdData_DI_0  in  DATA_WIDTH  from RAM read data 0
RamRdData_DI_1  in  DATA_WIDTH  from RAM read data 1
InitDone_SO  out  1  high once the clear sequence has completed

Behaviour:
- Single clock. Reset is synchronous and active-low: on a rising edge with Rst_RBI=0, the state is cleared.
- State machine: INIT -> RUN.
- Reset values: state=INIT, init counter=0, FIFO count/pointers=0, InitDone_SO=0.
- INIT:
  - RamWrEn_SO=1, RamWrAddr_DO=init counter, RamWrData_DO=INIT_VALUE.
  - Counter increments each cycle.
  - After the write to DATA_DEPTH-1 (DATA_DEPTH cycles in total), move to RUN.
  - Both ready outputs are 0.
  - RdData_DO_x = RamRdData_DI_x with no forwarding; the contents are not checked.
- RUN:
  - InitDone_SO=1 (registered; rises on the first RUN cycle).
  - Acceptance uses the registered count only; no credit is given for a same-cycle drain:
    - WrReady_SO_0 = (count <= FIFO_DEPTH-1)
    - WrReady_SO_1 = (count <= FIFO_DEPTH-2)
    - Ready outputs do not depend on valid inputs.
  - Enqueue order when both fire in the same cycle: port 0 first, then port 1. Port 1 is therefore younger and wins on equal addresses.
  - Drain: if count>0, RamWrEn_SO=1 with the head entry's address and data, combinationally from the FIFO head. The head pops at that edge.
  - If count=0, RamWrEn_SO=0 and the address/data outputs hold their last values.
  - Per edge, count_next = count + pushes − pop; simultaneous push and pop are legal. Pointers wrap modulo FIFO_DEPTH.
  - Latency: a write accepted at edge k is written to the RAM at edge k+1 if the FIFO was empty.
  - Forwarding:
    - RdData_DO_x = data of the youngest valid FIFO entry whose address equals RdAddr_DI_x. This includes the head being drained this cycle.
    - If no entry matches, RdData_DO_x = RamRdData_DI_x.
    - Same-cycle incoming requests are not forwarded; they become visible on the cycle after acceptance.
    - Purely combinational.
- Reset asserted mid-operation:
  - Pending writes are discarded, not written.
  - The block re-enters INIT and re-clears the RAM.
- Addresses >= DATA_DEPTH are undefined; a simulation-only assertion flags an accepted address >= DATA_DEPTH.

Test Plan:
- INIT clear, DATA_DEPTH=8: release reset -> RamWrEn_SO=1 with addresses 0..7 on 8 consecutive cycles, data 0; InitDone_SO=1 on cycle 9; readies 0 throughout INIT.
- Dual write: in RUN with an empty FIFO, same cycle port0 (addr 3, 0xAAAA) and port1 (addr 5, 0xBBBB) -> RAM writes addr 3 at the next edge, addr 5 at the edge after; RdAddr_DI_0=5 returns 0xBBBB on the cycle after acceptance, before the RAM holds it.
- Same-address ordering: port0 (addr 7, 0x1111) and port1 (addr 7, 0x2222) in one cycle -> RdData for addr 7 = 0x2222 while pending; final RAM value 0x2222; RAM write order 0x1111 then 0x2222.
- Backpressure, FIFO_DEPTH=4: hold the drain queue by issuing dual writes every cycle -> WrReady_SO_1 drops at count=3, WrReady_SO_0 drops at count=4; no request is lost and each RAM write appears exactly once, in order.
- Reset mid-operation: with 3 pending entries, assert Rst_RBI for 1 cycle -> no pending address is written; INIT restarts at address 0; readies 0 until INIT ends.
- No-match read: FIFO holding addr 2 only, RdAddr_DI_1=4 -> RdData_DO_1 equals RamRdData_DI_1.
